// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: reads operands from a small register file,
// drives the ALU for one cycle, captures the result and writes it back (R0 reads as zero).
module alu_issue_ctrl #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 8,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic [2:0]        i_instr_op,
  input  logic              i_instr_ld,
  input  logic [REG_AW-1:0] i_instr_rd,
  input  logic [REG_AW-1:0] i_instr_rs1,
  input  logic [REG_AW-1:0] i_instr_rs2,
  input  logic [DATA_W-1:0] i_instr_imm,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [2:0]        o_alu_op,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_done_valid,
  output logic [REG_AW-1:0] o_done_rd,
  output logic [DATA_W-1:0] o_done_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [REG_AW-1:0]   r_rd;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [2:0]          r_alu_op;
  logic                w_accept;
  logic [DATA_W-1:0]   w_rs1_data;
  logic [DATA_W-1:0]   w_rs2_data;

  // R0 is never written, but reads are gated as well so it is zero by construction.
  assign w_rs1_data = (i_instr_rs1 == '0) ? '0 : r_regs[i_instr_rs1];
  assign w_rs2_data = (i_instr_rs2 == '0) ? '0 : r_regs[i_instr_rs2];
  assign o_dbg_data = (i_dbg_addr  == '0) ? '0 : r_regs[i_dbg_addr];

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_done_rd   = r_rd;
  assign o_done_data = r_result;

  always_comb begin
    w_state_next  = r_state;
    o_instr_ready = 1'b0;
    o_done_valid  = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        o_instr_ready = 1'b1;
        w_accept      = i_instr_valid;
        if (i_instr_valid) begin
          w_state_next = i_instr_ld ? WB : EXEC;
        end
      end
      EXEC: w_state_next = WB;
      WB: begin
        o_done_valid = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rd     <= '0;
      r_result <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rd <= i_instr_rd;
        if (i_instr_ld) begin
          r_result <= i_instr_imm;
        end else begin
          r_alu_b  <= w_rs1_data;
          r_alu_a  <= w_rs2_data;
          r_alu_op <= i_instr_op;
        end
      end
      if (r_state == EXEC) begin
        r_result <= i_alu_result;
      end
      // Write-back lands before the next IDLE operand read, so dependent instructions need no bypass.
      if ((r_state == WB) && (r_rd != '0)) begin
        r_regs[r_rd] <= r_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: behavioural ALU, a vector table of instructions,
// and hand-written sequences for back-to-back issue and reset during EXEC.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic        instr_ld;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_rs1;
  logic [2:0]  instr_rs2;
  logic [31:0] instr_imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        done_valid;
  logic [2:0]  done_rd;
  logic [31:0] done_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_ctrl #(.DATA_W(32), .NUM_REGS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_instr_op(instr_op), .i_instr_ld(instr_ld),
    .i_instr_rd(instr_rd), .i_instr_rs1(instr_rs1), .i_instr_rs2(instr_rs2),
    .i_instr_imm(instr_imm),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_result(alu_result),
    .o_done_valid(done_valid), .o_done_rd(done_rd), .o_done_data(done_data),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: result = b op a
  always_comb begin
    case (alu_op)
      3'd0: alu_result = alu_b + alu_a;
      3'd1: alu_result = alu_b - alu_a;
      3'd2: alu_result = alu_b << alu_a;
      3'd3: alu_result = (alu_b < alu_a) ? 32'd1 : 32'd0;
      3'd4: alu_result = alu_b ^ alu_a;
      3'd5: alu_result = alu_b >> alu_a;
      3'd6: alu_result = alu_b | alu_a;
      default: alu_result = alu_b & alu_a;
    endcase
  end

  typedef struct {
    logic        ld;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] model [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    instr_valid = 1'b1;
    instr_ld    = v.ld;
    instr_op    = v.op;
    instr_rd    = v.rd;
    instr_rs1   = v.rs1;
    instr_rs2   = v.rs2;
    instr_imm   = v.imm;
  endtask

  task automatic scramble();
    instr_op  = 3'd7;
    instr_rd  = 3'd7;
    instr_rs1 = 3'd7;
    instr_rs2 = 3'd7;
    instr_imm = 32'hA5A5_A5A5;
    instr_ld  = 1'b0;
  endtask

  // Issues one instruction from IDLE and checks every cycle up to the return to IDLE.
  task automatic issue(input vec_t v, input int idx);
    logic [31:0] ea, eb;
    eb = model[v.rs1];
    ea = model[v.rs2];
    drive(v);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    scramble();
    if (!v.ld) begin
      chk($sformatf("v%0d exec ready", idx), {31'd0, instr_ready}, 32'd0);
      chk($sformatf("v%0d exec done_valid", idx), {31'd0, done_valid}, 32'd0);
      chk($sformatf("v%0d alu_b", idx), alu_b, eb);
      chk($sformatf("v%0d alu_a", idx), alu_a, ea);
      chk($sformatf("v%0d alu_op", idx), {29'd0, alu_op}, {29'd0, v.op});
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d wb done_valid", idx), {31'd0, done_valid}, 32'd1);
    chk($sformatf("v%0d wb ready", idx), {31'd0, instr_ready}, 32'd0);
    chk($sformatf("v%0d done_rd", idx), {29'd0, done_rd}, {29'd0, v.rd});
    chk($sformatf("v%0d done_data", idx), done_data, v.exp);
    @(posedge clk); #1;
    if (v.rd != 3'd0) model[v.rd] = v.exp;
    dbg_addr = v.rd;
    #1;
    chk($sformatf("v%0d idle ready", idx), {31'd0, instr_ready}, 32'd1);
    chk($sformatf("v%0d idle done_valid", idx), {31'd0, done_valid}, 32'd0);
    chk($sformatf("v%0d dbg R%0d", idx, v.rd), dbg_data, model[v.rd]);
    $display("vec %0d: ld=%0d op=%0d rd=%0d rs1=%0d rs2=%0d -> done_data=0x%08h dbg=0x%08h",
             idx, v.ld, v.op, v.rd, v.rs1, v.rs2, done_data, dbg_data);
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 8; i++) model[i] = 32'd0;
    //          ld    op    rd    rs1   rs2   imm            exp
    vecs[0] = '{1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 32'd5,         32'd5};
    vecs[1] = '{1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 32'd3,         32'd3};
    vecs[2] = '{1'b0, 3'd0, 3'd3, 3'd1, 3'd2, 32'd0,         32'd8};
    vecs[3] = '{1'b0, 3'd1, 3'd4, 3'd2, 3'd1, 32'd0,         32'hFFFF_FFFE};
    vecs[4] = '{1'b0, 3'd3, 3'd5, 3'd2, 3'd1, 32'd0,         32'd1};
    vecs[5] = '{1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 3'd0, 3'd6, 3'd0, 3'd1, 32'd0,         32'd5};
    vecs[7] = '{1'b0, 3'd4, 3'd7, 3'd1, 3'd2, 32'd0,         32'd6};
    vecs[8] = '{1'b0, 3'd5, 3'd6, 3'd4, 3'd2, 32'd0,         32'h1FFF_FFFF};
    vecs[9] = '{1'b0, 3'd7, 3'd7, 3'd4, 3'd1, 32'd0,         32'd4};

    rst_n = 1'b0;
    instr_valid = 1'b0;
    scramble();
    dbg_addr = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset ready", {31'd0, instr_ready}, 32'd1);
    chk("reset done_valid", {31'd0, done_valid}, 32'd0);
    chk("reset alu_a", alu_a, 32'd0);
    chk("reset alu_b", alu_b, 32'd0);
    chk("reset done_data", done_data, 32'd0);
    chk("reset dbg R1", dbg_data, 32'd0);
    $display("reset: ready=%0d done_valid=%0d", instr_ready, done_valid);

    for (int i = 0; i < 10; i++) issue(vecs[i], i);

    // Back-to-back dependent pair with valid held high: add R3=R1+R2, then sll R3=R3<<R1
    v = '{1'b0, 3'd0, 3'd3, 3'd1, 3'd2, 32'd0, 32'd8};
    drive(v);
    @(posedge clk); #1;
    v = '{1'b0, 3'd2, 3'd3, 3'd3, 3'd1, 32'd0, 32'h100};
    drive(v);
    chk("b2b add exec ready", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b2b add wb ready", {31'd0, instr_ready}, 32'd0);
    chk("b2b add done_valid", {31'd0, done_valid}, 32'd1);
    chk("b2b add done_data", done_data, 32'd8);
    @(posedge clk); #1;
    chk("b2b idle ready", {31'd0, instr_ready}, 32'd1);
    chk("b2b idle done_valid", {31'd0, done_valid}, 32'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    scramble();
    chk("b2b sll exec ready", {31'd0, instr_ready}, 32'd0);
    chk("b2b sll alu_b", alu_b, 32'd8);
    chk("b2b sll alu_a", alu_a, 32'd5);
    chk("b2b sll alu_op", {29'd0, alu_op}, 32'd2);
    @(posedge clk); #1;
    chk("b2b sll done_valid", {31'd0, done_valid}, 32'd1);
    chk("b2b sll done_rd", {29'd0, done_rd}, 32'd3);
    chk("b2b sll done_data", done_data, 32'h100);
    @(posedge clk); #1;
    dbg_addr = 3'd3;
    #1;
    chk("b2b dbg R3", dbg_data, 32'h100);
    $display("b2b: R3=0x%08h", dbg_data);

    // Reset during EXEC of or rd=7 drops the instruction
    v = '{1'b0, 3'd6, 3'd7, 3'd1, 3'd2, 32'd0, 32'd7};
    drive(v);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    scramble();
    chk("rst-exec in exec ready", {31'd0, instr_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst-exec alu_a", alu_a, 32'd0);
    chk("rst-exec alu_b", alu_b, 32'd0);
    chk("rst-exec alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst-exec done_valid", {31'd0, done_valid}, 32'd0);
    chk("rst-exec done_rd", {29'd0, done_rd}, 32'd0);
    chk("rst-exec done_data", done_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dbg_addr = 3'd7;
    #1;
    chk("rst-exec ready after release", {31'd0, instr_ready}, 32'd1);
    chk("rst-exec dbg R7", dbg_data, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst-exec no done c%0d", c), {31'd0, done_valid}, 32'd0);
    end
    dbg_addr = 3'd1;
    #1;
    chk("rst-exec dbg R1 cleared", dbg_data, 32'd0);
    $display("reset during exec: R7=0x%08h ready=%0d", dbg_data, instr_ready);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
